cdc_xfer_arbiter: RTL and testbench
===================================

// Module: cdc_xfer_arbiter
// PURPOSE
//  clk1-domain sender/arbiter for a toggle-handshake crossing into clk2.
//  Two clk1 requesters share one crossing channel; round-robin arbitration.
//  Granted word is held stable in a register and announced by flipping a registered, glitch-free toggle.
//  Completion is the clk2 ack toggle, synchronized back into clk1; the clk2 receiver is a separate block.
// PARAMETERS
//  DATA_W       8    width of transferred word
//  SYNC_STAGES  2    flops in ack_tgl synchronizer (>=2)
//  TIMEOUT_CYC  64   clk1 cycles in WAIT_ACK before timeout_err (macro only)
// PORTS
//  clk1         in   1       clock, sender domain
//  rst1         in   1       reset: asynchronous, active-high; clears all state
//  req0         in   1       requester 0 level request; hold until done0
//  data0        in   DATA_W  requester 0 word; hold stable while req0
//  req1         in   1       requester 1 level request
//  data1        in   DATA_W  requester 1 word
//  done0        out  1       1-cycle pulse: requester 0 transfer acknowledged
//  done1        out  1       1-cycle pulse: requester 1 transfer acknowledged
//  xfer_data    out  DATA_W  registered word to clk2; constant during handshake
//  xfer_tgl     out  1       registered toggle to clk2; flips once per transfer
//  ack_tgl      in   1       async ack toggle from clk2 (mirrors xfer_tgl)
//  busy         out  1       1 while state != IDLE
//  timeout_err  out  1       sticky ack-timeout flag (0 without macro)
// BEHAVIOUR
//  Reset: xfer_tgl=0, xfer_data=0, done0/1=0, busy=0, timeout_err=0, sync flops=0, state=IDLE, rr_last=1 (req0 wins first tie).
//  ack_s = ack_tgl after SYNC_STAGES clk1 flops; channel idle when ack_s==xfer_tgl.
//  FSM IDLE -> CAPTURE -> LAUNCH -> WAIT_ACK -> IDLE:
//   IDLE: if req0|req1 and ack_s==xfer_tgl: pick winner -> CAPTURE.
//    one requester -> it wins; both -> the one != rr_last.
//   CAPTURE: xfer_data <= winner's data; gnt_id latched -> LAUNCH.
//   LAUNCH: xfer_tgl <= ~xfer_tgl (data stable >=1 clk1 before toggle) -> WAIT_ACK.
//   WAIT_ACK: when ack_s==xfer_tgl: done[gnt_id] pulses 1 cycle, rr_last<=gnt_id -> IDLE.
//  Latency: req seen in IDLE at edge N -> data reg edge N+1 -> xfer_tgl flip edge N+2.
//  Done->next grant: new arbitration the cycle after returning to IDLE (min 1 idle cycle).
//  busy asserts from CAPTURE through WAIT_ACK, deasserts in the cycle done pulses.
//  xfer_data, xfer_tgl change only in CAPTURE/LAUNCH; never combinational.
//  req dropped after grant: ignored; transfer completes, done still pulses.
//  req asserted mid-transfer: waits; served next IDLE per round-robin.
//  Same requester re-requesting while other waits: other wins next (strict alternation).
//  done0 and done1 never both high; at most one transfer outstanding.
//  rst1 mid-transfer: immediate return to reset values; clk2 side must be reset (rst2) too so toggles agree.
//  ack_tgl toggling with no transfer outstanding: ignored (IDLE waits for ack_s==xfer_tgl).
// CONFIGURATION
//  CDC_XFER_TIMEOUT_EN defined: counter runs in WAIT_ACK, cleared on entry.
//   Reaching TIMEOUT_CYC sets timeout_err (sticky until rst1); FSM keeps waiting, no abort.
//  Undefined: no counter; timeout_err tied 0; WAIT_ACK waits indefinitely.
// TESTING
//  rst1 pulse -> all outputs 0; rst1 deassert with req0=1 -> xfer_data=data0 at edge+1, xfer_tgl=1 at edge+2.
//  req0 only, data0=8'hA5; loop ack_tgl=xfer_tgl after 3 cycles -> done0 pulse 1 cycle after ack_s matches, xfer_data=A5 throughout.
//  req0,req1 both held, 4 transfers -> grant order 0,1,0,1; done0/done1 alternate, never together.
//  req1 dropped after CAPTURE -> transfer completes, done1 pulses, no extra grant to 1.
//  rst1 asserted in WAIT_ACK -> next cycle xfer_tgl=0, busy=0, done0/1=0; fresh transfer works.
//  CDC_XFER_TIMEOUT_EN, TIMEOUT_CYC=8, ack held -> timeout_err=1 after 8 WAIT_ACK cycles; late ack -> done pulses, flag stays 1.

Source files
------------

// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter
//   clk1-domain sender for a toggle-handshake crossing into clk2. Two level
//   requesters share one channel under round-robin arbitration. The granted
//   word is held in xfer_data and announced by flipping xfer_tgl. Completion
//   is the clk2 ack toggle, synchronized into clk1. The receiver is a
//   separate block.
//
// Optional feature macro: CDC_XFER_TIMEOUT_EN
//   defined   : WAIT_ACK cycle counter; timeout_err is a sticky flag that is
//               set after TIMEOUT_CYC cycles without an ack (the transfer
//               still waits).
//   undefined : no counter; timeout_err tied low.
//
// Ports
//   clk1, rst1          sender clock, asynchronous active-high reset
//   req0/req1           level requests, held until the matching done pulse
//   data0/data1         request words, stable while requesting
//   done0/done1         1-cycle completion pulses (never both high)
//   xfer_data           registered word to clk2, constant during handshake
//   xfer_tgl            registered toggle to clk2, flips once per transfer
//   ack_tgl             asynchronous ack toggle from clk2
//   busy                high while the FSM is not IDLE
//   timeout_err         sticky ack-timeout flag
module cdc_xfer_arbiter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk1,
  input  logic              rst1,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] xfer_data,
  output logic              xfer_tgl,
  input  logic              ack_tgl,
  output logic              busy,
  output logic              timeout_err
);

  if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("cdc_xfer_arbiter: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    LAUNCH   = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   ack_sync_q;
  logic                     ack_s;
  logic                     chan_idle;
  logic                     gnt_q, gnt_d;
  logic                     rr_last_q, rr_last_d;
  logic [DATA_W-1:0]        xfer_data_q, xfer_data_d;
  logic                     xfer_tgl_q, xfer_tgl_d;
  logic                     done0_q, done0_d;
  logic                     done1_q, done1_d;

  assign ack_s     = ack_sync_q[SYNC_STAGES-1];
  assign chan_idle = (ack_s == xfer_tgl_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_last_d   = rr_last_q;
    xfer_data_d = xfer_data_q;
    xfer_tgl_d  = xfer_tgl_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // No arbitration in the done-pulse cycle: the finishing requester
        // still holds its level request and must not be re-granted on it.
        if ((req0 || req1) && chan_idle && !(done0_q || done1_q)) begin
          gnt_d   = (req0 && req1) ? ~rr_last_q : req1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        xfer_data_d = gnt_q ? data1 : data0;
        state_d     = LAUNCH;
      end
      LAUNCH: begin
        xfer_tgl_d = ~xfer_tgl_q;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (chan_idle) begin
          done0_d   = ~gnt_q;
          done1_d   = gnt_q;
          rr_last_d = gnt_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      state_q     <= IDLE;
      ack_sync_q  <= '0;
      gnt_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      xfer_data_q <= '0;
      xfer_tgl_q  <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl};
      gnt_q       <= gnt_d;
      rr_last_q   <= rr_last_d;
      xfer_data_q <= xfer_data_d;
      xfer_tgl_q  <= xfer_tgl_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
    end
  end

`ifdef CDC_XFER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_err_q, tmo_err_d;

  // Counter is cleared while launching so it starts at zero on WAIT_ACK entry.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;
    if (state_q == LAUNCH) begin
      tmo_cnt_d = '0;
    end else if (state_q == WAIT_ACK) begin
      if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        tmo_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign xfer_data = xfer_data_q;
  assign xfer_tgl  = xfer_tgl_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
module tb_cdc_xfer_arbiter;

  localparam int unsigned DW = 8;
`ifdef CDC_XFER_TIMEOUT_EN
  localparam int unsigned TB_TO = 8;
`else
  localparam int unsigned TB_TO = 64;
`endif

  logic          clk1 = 1'b0;
  logic          rst1 = 1'b1;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [DW-1:0] data0 = '0;
  logic [DW-1:0] data1 = '0;
  logic          done0, done1, xfer_tgl, busy, timeout_err;
  logic [DW-1:0] xfer_data;
  logic          ack_tgl = 1'b0;
  logic          ack_en  = 1'b0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];
  logic rr_m    = 1'b1;
  logic exp_tgl = 1'b0;

  cdc_xfer_arbiter #(
    .DATA_W(DW),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(TB_TO)
  ) dut (
    .clk1(clk1),
    .rst1(rst1),
    .req0(req0),
    .data0(data0),
    .req1(req1),
    .data1(data1),
    .done0(done0),
    .done1(done1),
    .xfer_data(xfer_data),
    .xfer_tgl(xfer_tgl),
    .ack_tgl(ack_tgl),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk1 = ~clk1;

  // clk2-side receiver stand-in: mirrors xfer_tgl a few cycles after it flips.
  int ack_dly = 0;
  always @(negedge clk1) begin
    if (rst1) begin
      ack_tgl = 1'b0;
      ack_dly = 0;
    end else if (ack_en && ack_tgl !== xfer_tgl) begin
      if (ack_dly == 2) begin
        ack_tgl = xfer_tgl;
        ack_dly = 0;
      end else begin
        ack_dly++;
      end
    end else begin
      ack_dly = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of the arbitration decision; pushes the expected grant.
  task automatic push_grant(input logic r0, input logic r1);
    exp_t e;
    e.id   = (r0 && r1) ? ~rr_m : r1;
    e.data = e.id ? data1 : data0;
    rr_m   = e.id;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag, input bit drop0, input bit drop1);
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk1);
      check({tag, "_done_excl"}, {31'd0, done0 & done1}, 32'd0);
      if (done0 === 1'b1 || done1 === 1'b1) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          exp_tgl = ~exp_tgl;
          check({tag, "_done_id"}, {30'd0, done1, done0}, e.id ? 32'd2 : 32'd1);
          check({tag, "_data"}, {24'd0, xfer_data}, {24'd0, e.data});
          check({tag, "_tgl"}, {31'd0, xfer_tgl}, {31'd0, exp_tgl});
          check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        end
        if (drop0) req0 = 1'b0;
        if (drop1) req1 = 1'b0;
      end
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      @(negedge clk1);
      check({tag, "_pulse_width"}, {30'd0, done1, done0}, 32'd0);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk1);
    check("rst_done0", {31'd0, done0}, 32'd0);
    check("rst_done1", {31'd0, done1}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tgl", {31'd0, xfer_tgl}, 32'd0);
    check("rst_data", {24'd0, xfer_data}, 32'd0);
    check("rst_tmo", {31'd0, timeout_err}, 32'd0);

    // Release reset with req0 already high: latency check
    req0   = 1'b1;
    data0  = 8'h3C;
    ack_en = 1'b1;
    push_grant(1'b1, 1'b0);
    rst1 = 1'b0;
    @(posedge clk1); #1;
    check("lat_busy_n0", {31'd0, busy}, 32'd1);
    check("lat_data_n0", {24'd0, xfer_data}, 32'd0);
    @(posedge clk1); #1;
    check("lat_data_n1", {24'd0, xfer_data}, 32'h3C);
    check("lat_tgl_n1", {31'd0, xfer_tgl}, 32'd0);
    @(posedge clk1); #1;
    check("lat_tgl_n2", {31'd0, xfer_tgl}, 32'd1);
    wait_done("first", 1'b1, 1'b0);
    repeat (3) @(negedge clk1);
    check("first_no_regrant", {31'd0, busy}, 32'd0);

    // Single requester 0 with A5
    data0 = 8'hA5;
    req0  = 1'b1;
    push_grant(1'b1, 1'b0);
    wait_done("a5", 1'b1, 1'b0);

    // Both held: four alternating transfers
    data0 = 8'h11;
    data1 = 8'h22;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int k = 0; k < 4; k++) push_grant(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) wait_done("rr", 1'b0, 1'b0);
    wait_done("rr_last", 1'b1, 1'b1);
    repeat (4) @(negedge clk1);
    check("rr_idle", {31'd0, busy}, 32'd0);

    // req1 dropped after capture
    data1 = 8'h5A;
    req1  = 1'b1;
    push_grant(1'b0, 1'b1);
    @(posedge clk1); @(posedge clk1); #1;
    req1 = 1'b0;
    wait_done("drop1", 1'b0, 1'b0);
    repeat (10) @(negedge clk1);
    check("drop1_no_extra", {31'd0, busy}, 32'd0);
    check("drop1_queue_empty", exp_q.size(), 32'd0);

    // Reset while waiting for the ack
    ack_en = 1'b0;
    data0  = 8'h77;
    req0   = 1'b1;
    repeat (6) @(negedge clk1);
    check("wa_busy", {31'd0, busy}, 32'd1);
    rst1 = 1'b1;
    #1;
    check("wa_rst_tgl", {31'd0, xfer_tgl}, 32'd0);
    check("wa_rst_busy", {31'd0, busy}, 32'd0);
    check("wa_rst_done", {30'd0, done1, done0}, 32'd0);
    repeat (2) @(negedge clk1);
    exp_q.delete();
    rr_m    = 1'b1;
    exp_tgl = 1'b0;
    ack_en  = 1'b1;
    push_grant(1'b1, 1'b0);
    rst1 = 1'b0;
    wait_done("post_rst", 1'b1, 1'b0);

    // Ack withheld: timeout flag behaviour
    ack_en = 1'b0;
    data0  = 8'h99;
    req0   = 1'b1;
    push_grant(1'b1, 1'b0);
`ifdef CDC_XFER_TIMEOUT_EN
    @(posedge clk1);
    repeat (9) @(posedge clk1);
    #1;
    check("tmo_before", {31'd0, timeout_err}, 32'd0);
    @(posedge clk1); #1;
    check("tmo_set", {31'd0, timeout_err}, 32'd1);
    ack_en = 1'b1;
    wait_done("tmo_late", 1'b1, 1'b0);
    check("tmo_sticky", {31'd0, timeout_err}, 32'd1);
`else
    repeat (80) @(posedge clk1);
    #1;
    check("tmo_off", {31'd0, timeout_err}, 32'd0);
    check("tmo_off_busy", {31'd0, busy}, 32'd1);
    ack_en = 1'b1;
    wait_done("tmo_off_late", 1'b1, 1'b0);
    check("tmo_off_after", {31'd0, timeout_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
